// File: rtl/reg_files.sv
// reg_files: 32 x 32-bit general-purpose register file for the decode stage.
// Two combinational read ports, one synchronous write port, write-through
// bypass so decode can capture a result in the same cycle it is written back.
// Register 0 is hardwired to zero; destination index 0 means "no write".
module reg_files (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [9:0]  rs_rt,
  input  logic [4:0]  rwd,
  input  logic [31:0] wb_data,
  output logic [31:0] val_rs,
  output logic [31:0] val_rt
);

  logic [31:0][31:0] regs_q;
  logic [31:0][31:0] regs_d;

  logic [4:0] rs_idx;
  logic [4:0] rt_idx;
  logic       wr_active;

  assign rs_idx    = rs_rt[9:5];
  assign rt_idx    = rs_rt[4:0];
  assign wr_active = (rwd != 5'd0);

  // Next storage contents: copy current state, overlay the write-back result.
  always_comb begin
    regs_d = regs_q;
    if (wr_active) begin
      regs_d[rwd] = wb_data;
    end
    regs_d[0] = 32'h0000_0000;
  end

  // Storage register with asynchronous clear of every entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: zero for r0 or during reset, bypassed data on index match.
  always_comb begin
    val_rs = 32'h0000_0000;
    val_rt = 32'h0000_0000;
    if (RST_N) begin
      if (rs_idx != 5'd0) begin
        if (wr_active && (rs_idx == rwd)) begin
          val_rs = wb_data;
        end else begin
          val_rs = regs_q[rs_idx];
        end
      end
      if (rt_idx != 5'd0) begin
        if (wr_active && (rt_idx == rwd)) begin
          val_rt = wb_data;
        end else begin
          val_rt = regs_q[rt_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_files.sv
// tb_reg_files: scoreboard bench for reg_files. Stimulus pushes expected
// read values from an array-based register model; a monitor pops and compares.
module tb_reg_files;

  logic        CLK;
  logic        RST_N;
  logic [9:0]  rs_rt;
  logic [4:0]  rwd;
  logic [31:0] wb_data;
  logic [31:0] val_rs;
  logic [31:0] val_rt;

  typedef struct {
    string       name;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_regs[32];
  int          vectors;
  int          miscompares;

  reg_files dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .rs_rt   (rs_rt),
    .rwd     (rwd),
    .wb_data (wb_data),
    .val_rs  (val_rs),
    .val_rt  (val_rt)
  );

  // Free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // What a read port should show for the architectural register state.
  function automatic logic [31:0] expected_read(input logic rst_n, input logic [4:0] idx,
                                                input logic [4:0] w, input logic [31:0] d);
    if (!rst_n || idx == 5'd0) return 32'h0;
    if (w != 5'd0 && idx == w) return d;
    return model_regs[idx];
  endfunction

  // One cycle: drive inputs, queue expected reads, then commit the write in the model.
  task automatic apply_stimulus(input string name, input logic rst_n, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] w, input logic [31:0] d);
    exp_t e;
    RST_N   = rst_n;
    rs_rt   = {rs, rt};
    rwd     = w;
    wb_data = d;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    end
    e.name   = name;
    e.exp_rs = expected_read(rst_n, rs, w, d);
    e.exp_rt = expected_read(rst_n, rt, w, d);
    exp_q.push_back(e);
    @(posedge CLK);
    if (rst_n && w != 5'd0) model_regs[w] = d;
    #1;
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge CLK) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output(e);
    end
  end

  task automatic check_output(input exp_t e);
    vectors++;
    if (val_rs !== e.exp_rs || val_rt !== e.exp_rt) begin
      miscompares++;
      $display("[TB] FAIL %s: val_rs=%h val_rt=%h expected val_rs=%h val_rt=%h",
               e.name, val_rs, val_rt, e.exp_rs, e.exp_rt);
    end
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [31:0] v;
    vectors     = 0;
    miscompares = 0;
    RST_N   = 1'b0;
    rs_rt   = '0;
    rwd     = '0;
    wb_data = '0;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    #6;

    apply_stimulus("reset_state", 1'b0, 5'd5, 5'd31, 5'd0, 32'h0);
    apply_stimulus("reset_release", 1'b1, 5'd5, 5'd31, 5'd0, 32'h0);

    apply_stimulus("write_r5", 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF);
    apply_stimulus("read_r5", 1'b1, 5'd5, 5'd0, 5'd0, 32'h0);
    apply_stimulus("reset_pulse", 1'b0, 5'd5, 5'd5, 5'd5, 32'hCAFE_F00D);
    apply_stimulus("after_reset", 1'b1, 5'd5, 5'd5, 5'd0, 32'h0);

    apply_stimulus("write_r3", 1'b1, 5'd0, 5'd0, 5'd3, 32'h1234_5678);
    apply_stimulus("read_r3", 1'b1, 5'd3, 5'd3, 5'd0, 32'h0);

    for (int i = 0; i < 4; i++)
      apply_stimulus("r0_protect", 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);

    apply_stimulus("write_r7", 1'b1, 5'd0, 5'd0, 5'd7, 32'h0000_0001);
    apply_stimulus("write_r2", 1'b1, 5'd0, 5'd0, 5'd2, 32'h0000_0022);
    apply_stimulus("bypass_r7", 1'b1, 5'd7, 5'd2, 5'd7, 32'h0000_00AA);
    apply_stimulus("stored_r7", 1'b1, 5'd7, 5'd7, 5'd0, 32'h0);
    apply_stimulus("bypass_both", 1'b1, 5'd2, 5'd2, 5'd2, 32'h5555_AAAA);

    apply_stimulus("write_r1", 1'b1, 5'd0, 5'd0, 5'd1, 32'h0000_0011);
    apply_stimulus("write_r31", 1'b1, 5'd0, 5'd0, 5'd31, 32'h0000_3131);
    apply_stimulus("dual_ports", 1'b1, 5'd1, 5'd31, 5'd0, 32'h0);
    apply_stimulus("dual_swapped", 1'b1, 5'd31, 5'd1, 5'd0, 32'h0);

    for (int i = 1; i < 32; i++) begin
      v = i * 32'h0101_0101;
      apply_stimulus("sweep_write", 1'b1, 5'(i), 5'd0, 5'(i), v);
    end
    for (int i = 0; i < 32; i++)
      apply_stimulus("sweep_read", 1'b1, 5'(i), 5'(31 - i), 5'd0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic       r;
      logic [4:0] w;
      r = ($urandom_range(0, 49) != 0);
      w = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      apply_stimulus("random", r, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     w, $urandom);
    end

    repeat (2) @(posedge CLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
